// File: rtl/simd_prog_loader_if.sv
// Host byte stream, memory write ports and CPU control for simd_prog_loader.
// master = loader side, slave = host/CPU side.
interface simd_prog_loader_if #(
    parameter int ADDR_W = 10,
    parameter int INST_W = 18,
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_wdata;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              cpu_rst;
    logic              cpu_done;
    logic              busy;
    logic              run_done;
    logic              err;

    modport master (
        input  in_valid, in_data, cpu_done,
        output in_ready, imem_we, imem_addr, imem_wdata,
               dmem_we, dmem_addr, dmem_wdata, cpu_rst, busy, run_done, err
    );
    modport slave (
        output in_valid, in_data, cpu_done,
        input  in_ready, imem_we, imem_addr, imem_wdata,
               dmem_we, dmem_addr, dmem_wdata, cpu_rst, busy, run_done, err
    );
endinterface

// File: rtl/simd_prog_loader.sv
// Byte-stream program/data loader for the SIMD core: fills imem/dmem, then runs the CPU.
// Optional LOADER_CHECKSUM_EN appends an XOR checksum byte to every load packet.
module simd_prog_loader #(
    parameter int ADDR_W      = 10,
    parameter int INST_W      = 18,
    parameter int DATA_W      = 16,
    parameter int RUN_TIMEOUT = 65535
) (
    input  logic               i_clk,
    input  logic               i_rst,
    simd_prog_loader_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR_H  = 3'd1;
    localparam logic [2:0] S_ADDR_L  = 3'd2;
    localparam logic [2:0] S_COUNT   = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;
    localparam logic [2:0] S_RUN     = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK   = 3'd7;
    localparam logic [2:0] S_PKT_END = S_CHECK;
`else
    localparam logic [2:0] S_PKT_END = S_IDLE;
`endif

    localparam int SH_W = INST_W - 8;
    localparam int TW   = $clog2(RUN_TIMEOUT + 1);

    logic [2:0]        r_state;
    logic              r_live;
    logic              r_is_inst;
    logic [ADDR_W-9:0] r_addr_h;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_cnt;
    logic [1:0]        r_bidx;
    logic [SH_W-1:0]   r_shift;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [INST_W-1:0] r_imem_wdata;
    logic              r_dmem_we;
    logic [ADDR_W-1:0] r_dmem_addr;
    logic [DATA_W-1:0] r_dmem_wdata;
    logic              r_cpu_rst;
    logic              r_run_done;
    logic              r_err;
    logic [TW-1:0]     r_timer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic              w_acc;
    logic              w_last_byte;
    logic [INST_W-1:0] w_iword;

    assign w_acc       = bus.in_valid & bus.in_ready;
    assign w_last_byte = r_is_inst ? (r_bidx == 2'd2) : (r_bidx == 2'd1);
    // Older bytes shift up; the top bits of the first instruction byte fall off.
    assign w_iword     = {r_shift, bus.in_data};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_live       <= 1'b0;
            r_is_inst    <= 1'b0;
            r_addr_h     <= '0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_bidx       <= '0;
            r_shift      <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_cpu_rst    <= 1'b1;
            r_run_done   <= 1'b0;
            r_err        <= 1'b0;
            r_timer      <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_live     <= 1'b1;
            r_imem_we  <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_run_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            if (w_acc)
                r_csum <= (r_state == S_IDLE) ? bus.in_data : (r_csum ^ bus.in_data);
`endif
            case (r_state)
                S_IDLE: if (w_acc) begin
                    case (bus.in_data[7:6])
                        2'b00, 2'b01: begin
                            r_is_inst <= ~bus.in_data[6];
                            r_state   <= S_ADDR_H;
                        end
                        2'b10:   r_state <= S_RUN;
                        default: r_err   <= 1'b1;
                    endcase
                end
                S_ADDR_H: if (w_acc) begin
                    r_addr_h <= bus.in_data[ADDR_W-9:0];
                    r_state  <= S_ADDR_L;
                end
                S_ADDR_L: if (w_acc) begin
                    r_addr  <= {r_addr_h, bus.in_data};
                    r_state <= S_COUNT;
                end
                S_COUNT: if (w_acc) begin
                    r_cnt   <= bus.in_data;
                    r_bidx  <= '0;
                    r_state <= S_PAYLOAD;
                end
                S_PAYLOAD: if (w_acc) begin
                    r_shift <= w_iword[SH_W-1:0];
                    if (w_last_byte) begin
                        r_bidx <= '0;
                        if (r_is_inst) begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_addr;
                            r_imem_wdata <= w_iword;
                        end else begin
                            r_dmem_we    <= 1'b1;
                            r_dmem_addr  <= r_addr;
                            r_dmem_wdata <= w_iword[DATA_W-1:0];
                        end
                        r_addr <= r_addr + 1'b1;
                        if (r_cnt == 8'd0) r_state <= S_PKT_END;
                        else               r_cnt   <= r_cnt - 8'd1;
                    end else begin
                        r_bidx <= r_bidx + 2'd1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: if (w_acc) begin
                    if ((r_csum ^ bus.in_data) != 8'h00) r_err <= 1'b1;
                    r_state <= S_IDLE;
                end
`endif
                // First RUN cycle only releases the core; cpu_done is sampled once it runs.
                S_RUN: begin
                    if (r_cpu_rst) begin
                        r_cpu_rst <= 1'b0;
                        r_timer   <= '0;
                    end else if (bus.cpu_done) begin
                        r_cpu_rst  <= 1'b1;
                        r_run_done <= 1'b1;
                        r_state    <= S_DONE;
                    end else if (r_timer == TW'(RUN_TIMEOUT - 1)) begin
                        r_err      <= 1'b1;
                        r_cpu_rst  <= 1'b1;
                        r_run_done <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = r_live & (r_state != S_RUN) & (r_state != S_DONE);
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.dmem_we    = r_dmem_we;
    assign bus.dmem_addr  = r_dmem_addr;
    assign bus.dmem_wdata = r_dmem_wdata;
    assign bus.cpu_rst    = r_cpu_rst;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.run_done   = r_run_done;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_simd_prog_loader.sv
// Directed bench for simd_prog_loader: loads, wrap, run/timeout, illegal opcode, stall, reset.
// dut2 uses RUN_TIMEOUT=16 for the timeout case.
module tb_simd_prog_loader;
    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simd_prog_loader_if b ();
    simd_prog_loader_if b2 ();

    simd_prog_loader dut (.i_clk(clk), .i_rst(rst), .bus(b));
    simd_prog_loader #(.RUN_TIMEOUT(16)) dut2 (.i_clk(clk), .i_rst(rst), .bus(b2));

    int errs = 0;
    int checks = 0;
    logic [7:0] cs;
    logic [9:0]  iw_a[$];
    logic [17:0] iw_d[$];
    logic [9:0]  dw_a[$];
    logic [15:0] dw_d[$];
    int rd_n = 0;

    always @(negedge clk) begin
        if (b.imem_we) begin iw_a.push_back(b.imem_addr); iw_d.push_back(b.imem_wdata); end
        if (b.dmem_we) begin dw_a.push_back(b.dmem_addr); dw_d.push_back(b.dmem_wdata); end
        if (b.run_done) rd_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        iw_a.delete(); iw_d.delete(); dw_a.delete(); dw_d.delete();
    endtask

    task automatic send_byte(input logic [7:0] v);
        int n = 0;
        b.in_valid = 1'b1;
        b.in_data  = v;
        cs ^= v;
        while (!b.in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("ready_timeout", 32'(b.in_ready), 32'd1);
        @(posedge clk); #1;
        b.in_valid = 1'b0;
    endtask

    task automatic send_pkt(input byte_q_t p, input logic [7:0] bad);
        cs = 8'h00;
        foreach (p[i]) send_byte(p[i]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs ^ bad);
`endif
    endtask

    initial begin
        int n, k;
        logic ok;
        b.in_valid = 0; b.in_data = 0; b.cpu_done = 0;
        b2.in_valid = 0; b2.in_data = 0; b2.cpu_done = 0;
        rst = 1'b0;
        cs = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(b.in_ready), 0);
        chk("rst_cpu_rst",  32'(b.cpu_rst), 1);
        chk("rst_busy",     32'(b.busy), 0);
        chk("rst_err",      32'(b.err), 0);
        chk("rst_we",       32'({b.imem_we, b.dmem_we, b.run_done}), 0);
        chk("rst_addr",     32'({b.imem_addr, b.dmem_addr}), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(b.in_ready), 1);

        // INST load, then DATA load with address wrap back-to-back
        clr();
        send_pkt('{8'h00, 8'h00, 8'h03, 8'h00, 8'h02, 8'hAB, 8'hCD}, 8'h00);
        send_pkt('{8'h40, 8'h03, 8'hFF, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78}, 8'h00);
        repeat (3) @(negedge clk);
        chk("inst_cnt",  32'(iw_a.size()), 1);
        chk("inst_addr", iw_a.size() > 0 ? 32'(iw_a[0]) : 32'hDEAD, 32'd3);
        chk("inst_data", iw_d.size() > 0 ? 32'(iw_d[0]) : 32'hDEAD, 32'h2ABCD);
        chk("data_cnt",  32'(dw_a.size()), 2);
        chk("data0_addr", dw_a.size() > 1 ? 32'(dw_a[0]) : 32'hDEAD, 32'd1023);
        chk("data0_data", dw_d.size() > 1 ? 32'(dw_d[0]) : 32'hDEAD, 32'h1234);
        chk("data1_addr", dw_a.size() > 1 ? 32'(dw_a[1]) : 32'hDEAD, 32'd0);
        chk("data1_data", dw_d.size() > 1 ? 32'(dw_d[1]) : 32'hDEAD, 32'h5678);
        chk("load_idle", 32'(b.busy), 0);

        // RUN: done asserted on the entry cycle must be ignored
        rd_n = 0;
        send_byte(8'h80);
        chk("run_entry_rst", 32'(b.cpu_rst), 1);
        chk("run_busy", 32'(b.busy), 1);
        b.cpu_done = 1'b1;
        @(posedge clk); #1;
        b.cpu_done = 1'b0;
        chk("run_released", 32'(b.cpu_rst), 0);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (b.cpu_rst || b.in_ready || b.run_done) ok = 1'b0;
        end
        chk("run_hold", 32'(ok), 1);
        b.cpu_done = 1'b1;
        k = 0;
        while (!b.run_done && k < 10) begin @(negedge clk); k++; end
        chk("run_done_seen", 32'(b.run_done), 1);
        chk("run_rst_back", 32'(b.cpu_rst), 1);
        b.cpu_done = 1'b0;
        @(negedge clk);
        chk("run_pulse_once", 32'(rd_n), 1);
        chk("run_idle", 32'({b.busy, b.in_ready}), 32'b01);
        chk("run_no_err", 32'(b.err), 0);

        // Timeout on dut2 (RUN_TIMEOUT=16)
        b2.in_valid = 1'b1; b2.in_data = 8'h80;
        @(posedge clk); #1;
        b2.in_valid = 1'b0;
        n = 0; k = 0;
        while (!b2.run_done && k < 200) begin
            @(negedge clk); k++;
            if (!b2.cpu_rst) n++;
        end
        chk("to_run_done", 32'(b2.run_done), 1);
        chk("to_cycles", 32'(n), 16);
        chk("to_err", 32'(b2.err), 1);
        chk("to_cpu_rst", 32'(b2.cpu_rst), 1);
        @(negedge clk);
        chk("to_idle", 32'(b2.busy), 0);

        // Illegal opcode
        clr();
        send_byte(8'hC0);
        repeat (3) @(negedge clk);
        chk("ill_err", 32'(b.err), 1);
        chk("ill_busy", 32'(b.busy), 0);
        chk("ill_writes", 32'(iw_a.size() + dw_a.size()), 0);

        // Host stalls mid-word in a DATA packet
        cs = 8'h00;
        send_byte(8'h41); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00);
        send_byte(8'h9A);
        ok = 1'b1;
        repeat (5) begin @(negedge clk); if (b.dmem_we) ok = 1'b0; end
        chk("stall_no_we", 32'(ok), 1);
        send_byte(8'hBC);
        chk("stall_we", 32'(b.dmem_we), 1);
        chk("stall_addr", 32'(b.dmem_addr), 32'd5);
        chk("stall_data", 32'(b.dmem_wdata), 32'h9ABC);
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs);
`endif
        repeat (3) @(negedge clk);
        chk("stall_cnt", 32'(dw_a.size()), 1);

        // Reset mid-payload
        clr();
        cs = 8'h00;
        send_byte(8'h40); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'hAA);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_cpu_rst", 32'(b.cpu_rst), 1);
        chk("mrst_busy", 32'(b.busy), 0);
        chk("mrst_ready", 32'(b.in_ready), 0);
        chk("mrst_err", 32'(b.err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_no_we", 32'(dw_a.size()), 0);
        send_pkt('{8'h40, 8'h00, 8'h20, 8'h00, 8'h11, 8'h22}, 8'h00);
        repeat (3) @(negedge clk);
        chk("post_cnt", 32'(dw_a.size()), 1);
        chk("post_addr", dw_a.size() > 0 ? 32'(dw_a[0]) : 32'hDEAD, 32'h20);
        chk("post_data", dw_d.size() > 0 ? 32'(dw_d[0]) : 32'hDEAD, 32'h1122);
        chk("good_pkt_err", 32'(b.err), 0);
`ifdef LOADER_CHECKSUM_EN
        send_pkt('{8'h40, 8'h00, 8'h21, 8'h00, 8'h33, 8'h44}, 8'h01);
        repeat (3) @(negedge clk);
        chk("bad_csum_err", 32'(b.err), 1);
        chk("bad_csum_idle", 32'(b.busy), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/simd_prog_loader.md
Name: simd_prog_loader

Overview:
- Host-side loader directly upstream of the SIMD CPU core.
- Accepts a byte stream with a valid/ready handshake and assembles 18-bit instruction words and 16-bit data words.
- Writes those words into the instruction and data memories, then releases the CPU from reset and waits for its done flag.
- Replaces the hard-coded memory initialisation in the processor wrapper with a run-time program/data path.

Parameters:
- ADDR_W, 10, memory address width (both memories).
- INST_W, 18, instruction word width; sent as 3 bytes, MSB first; unused upper bits of the first byte are dropped.
- DATA_W, 16, data word width; sent as 2 bytes, MSB first.
- RUN_TIMEOUT, 65535, maximum cycles in RUN waiting for cpu_done.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: host byte valid.
- in_data, input, 8: host byte.
- in_ready, output, 1: loader can accept a byte.
- imem_we, output, 1: instruction memory write strobe.
- imem_addr, output, ADDR_W: instruction write address.
- imem_wdata, output, INST_W: instruction write data.
- dmem_we, output, 1: data memory write strobe.
- dmem_addr, output, ADDR_W: data write address.
- dmem_wdata, output, DATA_W: data write data.
- cpu_rst, output, 1: active-high reset to the CPU core.
- cpu_done, input, 1: CPU done flag.
- busy, output, 1: loader not in IDLE.
- run_done, output, 1: one-cycle pulse when a run ends.
- err, output, 1: sticky error flag.

Behaviour:
- Reset values: in_ready=0 during reset; all write strobes, addresses and data=0; cpu_rst=1; busy=0; run_done=0; err=0; state=IDLE. Reset mid-packet discards any partial word and drops the CPU back into reset immediately.
- Handshake: a byte is accepted on a rising edge with in_valid && in_ready. in_ready=1 in IDLE, ADDR_H, ADDR_L, COUNT, PAYLOAD and CHECK; in_ready=0 in RUN and DONE.
- Command byte (IDLE), bits [7:6]:
  - 00 = INST load.
  - 01 = DATA load.
  - 10 = RUN.
  - 11 = illegal: byte consumed, err set, stay IDLE.
  - Bits [5:0] are ignored.
- Load packet:
  - After the command: ADDR_H, then ADDR_L; address = {ADDR_H,ADDR_L}[ADDR_W-1:0], upper bits ignored.
  - Next, COUNT byte N; the packet carries N+1 words (1..256).
  - Then PAYLOAD: 3 bytes per INST word or 2 bytes per DATA word.
- Write timing: the memory write occurs in the cycle after the last byte of a word is accepted. imem_we or dmem_we is high for exactly 1 cycle, with addr/wdata valid in that same cycle. Address post-increments after each write and wraps 2^ADDR_W-1 -> 0.
- Packet end: after the final word, return to IDLE (or go to CHECK, see below). Back-to-back packets are accepted with no idle cycles.
- RUN sequence:
  - Command 10 -> RUN state. cpu_rst deasserts the following cycle, and a timeout counter starts from 0.
  - cpu_done=1 -> DONE: cpu_rst reasserts, run_done pulses 1 cycle, then IDLE.
  - Counter reaching RUN_TIMEOUT -> err set, same exit path as cpu_done.
  - cpu_done high on the cycle of entry into RUN is ignored; only cycles with cpu_rst=0 count.
- busy=1 in every state except IDLE.
- err is cleared only by rst.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: each load packet ends with one extra byte in state CHECK. The XOR of all packet bytes (command through checksum) must equal 0x00; a mismatch sets err. Writes already issued are not rolled back.
- Undefined: no CHECK state; the packet ends after the last payload byte.

Test Plan:
- INST load: 00,00,03,00,02,AB,CD -> one imem_we, imem_addr=3, imem_wdata=18'h2ABCD; back to IDLE.
- DATA load with wrap: 40,03,FF,01,12,34,56,78 -> dmem writes (1023, 16'h1234) then (0, 16'h5678).
- RUN: cmd 80, cpu_done raised 20 cycles later -> cpu_rst=0 for those cycles, in_ready=0, then cpu_rst=1, run_done pulses once, busy=0.
- Timeout with RUN_TIMEOUT=16: cmd 80, cpu_done never raised -> err=1 after 16 cycles, cpu_rst=1, run_done pulses.
- Illegal opcode and stall: send C0 -> err=1, no writes. Deassert in_valid mid-word in a DATA packet -> no write until the final byte arrives.
- Reset mid-PAYLOAD (rst=0 after 1 of 2 bytes) -> no dmem_we, cpu_rst=1, state IDLE. With LOADER_CHECKSUM_EN: correct checksum -> err=0; checksum off by one -> err=1.
